bit_get_reader: RTL and testbench
=================================

Name: bit_get_reader

Overview:
- Read-side counterpart to the team's combinational bit-set writer.
- Holds a WIDTH-bit word and returns either one indexed bit or every bit in turn.
- Output uses a valid/ready handshake so a slow consumer (display, serial link, checker) can apply backpressure.
- Sits downstream of the bit-set logic: the modified word is loaded here, then read back bit by bit.

Parameters:
- WIDTH, 4, number of bits in the stored word (2..16).
- IDXW, 2, index width; must equal ceil(log2(WIDTH)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  capture din into the word register (IDLE only).
- din  input  WIDTH  word to store.
- req  input  1  single-bit read request (IDLE only).
- index  input  IDXW  bit position for req.
- scan_start  input  1  start a full LSB-first scan (IDLE only).
- out_ready  input  1  consumer accepts out_bit this cycle.
- out_valid  output  1  out_bit/out_index valid.
- out_bit  output  1  value of the selected bit.
- out_index  output  IDXW  position of out_bit.
- busy  output  1  high whenever state != IDLE.
- scan_done  output  1  one-cycle pulse after the final scan bit is accepted.
- word  output  WIDTH  current stored word.

Behaviour:
- States: IDLE, SINGLE, SCAN. All outputs are registered.
- Reset (rst_n low, asynchronous):
  - state=IDLE; word=0, out_valid=0, out_bit=0, out_index=0, scan_done=0; scan counter=0.
  - Takes effect immediately, including mid-operation.
  - Any in-flight read is abandoned; no partial handshake completes.
- IDLE: input priority is load > scan_start > req; only the winning input acts.
  - load: word<=din; stay IDLE.
  - scan_start: cnt<=0; out_valid<=1, out_bit<=word[0], out_index<=0; go to SCAN.
  - req: out_valid<=1, out_bit<=word[index], out_index<=index; go to SINGLE.
  - Latency: request in cycle N produces out_valid=1 at edge N+1.
  - index >= WIDTH (non-power-of-2 WIDTH): out_bit=0, out_index=index.
- SINGLE:
  - out_valid, out_bit and out_index hold stable while out_ready=0.
  - On out_valid&&out_ready: out_valid<=0, go to IDLE.
- SCAN, on each out_valid&&out_ready:
  - If cnt<WIDTH-1: cnt<=cnt+1 and present word[cnt+1].
  - If cnt==WIDTH-1: out_valid<=0, scan_done<=1 for exactly one cycle, go to IDLE.
  - No gaps: with out_ready held high, one bit is delivered per cycle.
  - Outputs hold while out_ready=0.
- While busy, load, req and scan_start are ignored (dropped, not queued), so the word is constant for the whole transaction.
- busy falls in the same cycle out_valid falls.
- scan_done coincides with the first IDLE cycle.
- out_ready is a don't-care while out_valid=0.
- A new request may be accepted in the cycle after return to IDLE, giving a back-to-back turnaround of 1 idle cycle.

Optional Feature:
- Macro: BIT_GET_READER_POPCOUNT_EN.
- When defined:
  - Adds output ones_count, width IDXW+1 (for WIDTH=4, 3 bits).
  - Registered count of set bits in word; updates on the edge after a load; resets to 0.
- When undefined: no ones_count port and no counting logic; all other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 mid-cycle -> all outputs 0 immediately, busy=0, word=4'b0000.
- Single read with backpressure: load din=4'b1010, then req index=1 with out_ready=0 for 3 cycles -> next edge out_valid=1, out_bit=1, out_index=1, stable 3 cycles; out_ready=1 -> out_valid=0 and busy=0 the following cycle.
- Full scan: word=4'b0110, scan_start, out_ready=1 -> out_bit 0,1,1,0 with out_index 0,1,2,3 on 4 consecutive cycles; scan_done=1 for exactly one cycle after index 3 is accepted.
- Scan with backpressure and blocked inputs: out_ready pattern 1,0,0,1,1,0,1, plus load din=4'b1111 and req during the scan -> exactly 4 bits delivered in order, inputs ignored, word remains 4'b0110.
- Priority and abort: load din=4'b0001 with req index=0 in the same cycle -> word=4'b0001, no out_valid; then start a scan and pull rst_n low at bit 2 -> out_valid=0 immediately, word=0, state IDLE.
- Popcount (macro defined): load 4'b1011 -> ones_count=3 on the next edge; load 4'b0000 -> ones_count=0.

Source files
------------

// File: rtl/bit_get_reader.sv
// bit_get_reader: holds a WIDTH-bit word and reads it back either as one
// indexed bit or as a full LSB-first scan over a valid/ready output.
// Optional feature: define BIT_GET_READER_POPCOUNT_EN to add a registered
// ones_count output (number of set bits in the stored word).
module bit_get_reader #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             req,
  input  logic [IDXW-1:0]  index,
  input  logic             scan_start,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_bit,
  output logic [IDXW-1:0]  out_index,
  output logic             busy,
  output logic             scan_done,
`ifdef BIT_GET_READER_POPCOUNT_EN
  output logic [IDXW:0]    ones_count,
`endif
  output logic [WIDTH-1:0] word
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] word_d;
  logic             valid_d, bit_d, done_d;
  logic [IDXW-1:0]  idx_d;
  logic [IDXW-1:0]  cnt, cnt_d, cnt_inc;
  logic             accept;

  // Out-of-range positions (non-power-of-two WIDTH) read as 0.
  function automatic logic get_bit(input logic [WIDTH-1:0] w,
                                   input logic [IDXW-1:0]  idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == IDXW'(i)) b = w[i];
    end
    return b;
  endfunction

  assign accept  = out_valid && out_ready;
  assign cnt_inc = cnt + IDXW'(1);
  assign busy    = (state != IDLE);

  // Next-state and next-output logic; commands are only honoured in IDLE.
  always_comb begin
    state_d = state;
    word_d  = word;
    valid_d = out_valid;
    bit_d   = out_bit;
    idx_d   = out_index;
    cnt_d   = cnt;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          word_d = din;
        end else if (scan_start) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          bit_d   = word[0];
          idx_d   = '0;
          state_d = SCAN;
        end else if (req) begin
          valid_d = 1'b1;
          bit_d   = get_bit(word, index);
          idx_d   = index;
          state_d = SINGLE;
        end
      end
      SINGLE: begin
        if (accept) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (accept) begin
          if (cnt == LAST_IDX) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
            bit_d = get_bit(word, cnt_inc);
            idx_d = cnt_inc;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word      <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_index <= '0;
      scan_done <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_d;
      word      <= word_d;
      out_valid <= valid_d;
      out_bit   <= bit_d;
      out_index <= idx_d;
      scan_done <= done_d;
      cnt       <= cnt_d;
    end
  end

`ifdef BIT_GET_READER_POPCOUNT_EN
  function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] w);
    logic [IDXW:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + (IDXW+1)'(w[i]);
    return c;
  endfunction

  // Count is taken from din at the load edge so it always matches word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_count <= '0;
    end else if (state == IDLE && load) begin
      ones_count <= popcount(din);
    end
  end
`endif

endmodule

// File: tb/tb_bit_get_reader.sv
// Testbench for bit_get_reader: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_bit_get_reader;
  localparam int WIDTH = 4;
  localparam int IDXW  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             req;
  logic [IDXW-1:0]  index;
  logic             scan_start;
  logic             out_ready;
  logic             out_valid;
  logic             out_bit;
  logic [IDXW-1:0]  out_index;
  logic             busy;
  logic             scan_done;
  logic [WIDTH-1:0] word;
`ifdef BIT_GET_READER_POPCOUNT_EN
  logic [IDXW:0]    ones_count;
`endif

  bit_get_reader #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .din(din), .req(req),
    .index(index), .scan_start(scan_start), .out_ready(out_ready),
    .out_valid(out_valid), .out_bit(out_bit), .out_index(out_index),
    .busy(busy), .scan_done(scan_done),
`ifdef BIT_GET_READER_POPCOUNT_EN
    .ones_count(ones_count),
`endif
    .word(word)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a pending-output queue. A read request enqueues the
  // bits it must deliver; each handshake pops one; empty queue == idle.
  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic            b;
  } ent_t;

  ent_t             mq[$];
  logic [WIDTH-1:0] m_word = '0;
  logic             m_done = 1'b0;
  logic             m_scan = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_word <= '0;
      m_done <= 1'b0;
      m_scan <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (mq.size() == 0) begin
        if (load) begin
          m_word <= din;
        end else if (scan_start) begin
          for (int i = 0; i < WIDTH; i++) mq.push_back('{idx: IDXW'(i), b: m_word[i]});
          m_scan <= 1'b1;
        end else if (req) begin
          mq.push_back('{idx: index, b: m_word[index]});
          m_scan <= 1'b0;
        end
      end else if (out_ready) begin
        mq.delete(0);
        if (mq.size() == 0 && m_scan) m_done <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("valid", 32'(out_valid), 32'(mq.size() != 0));
    check("busy", 32'(busy), 32'(mq.size() != 0));
    check("scan_done", 32'(scan_done), 32'(m_done));
    check("word", 32'(word), 32'(m_word));
    if (mq.size() != 0) begin
      check("out_bit", 32'(out_bit), 32'(mq[0].b));
      check("out_index", 32'(out_index), 32'(mq[0].idx));
    end
`ifdef BIT_GET_READER_POPCOUNT_EN
    check("ones_count", 32'(ones_count), 32'($countones(m_word)));
`endif
  end

  // Record every accepted (bit, index) pair.
  logic            acc_bit[$];
  logic [IDXW-1:0] acc_idx[$];
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      acc_bit.push_back(out_bit);
      acc_idx.push_back(out_index);
    end
  end

  task automatic check_scan(input string name);
    logic exp_b[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    check({name, "_count"}, 32'(acc_bit.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_bit.size()) begin
        check({name, "_bit"}, 32'(acc_bit[i]), 32'(exp_b[i]));
        check({name, "_idx"}, 32'(acc_idx[i]), 32'(i));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0; load = 1'b0; din = '0; req = 1'b0; index = '0;
    scan_start = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-cycle with a read in flight
    load = 1'b1; din = 4'b1111; @(negedge clk);
    load = 1'b0; req = 1'b1; index = 2'd2; @(negedge clk);
    req = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_word", 32'(word), 32'd0);
    check("rst_bit", 32'(out_bit), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_done", 32'(scan_done), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Single read with backpressure
    load = 1'b1; din = 4'b1010; @(negedge clk);
    load = 1'b0; req = 1'b1; index = 2'd1; out_ready = 1'b0; @(negedge clk);
    req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_bit", 32'(out_bit), 32'd1);
      check("single_index", 32'(out_index), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1; @(negedge clk);
    check("single_release_valid", 32'(out_valid), 32'd0);
    check("single_release_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;

    // Full scan, no backpressure
    load = 1'b1; din = 4'b0110; @(negedge clk);
    load = 1'b0; acc_bit.delete(); acc_idx.delete();
    scan_start = 1'b1; out_ready = 1'b1; @(negedge clk);
    scan_start = 1'b0;
    repeat (3) @(negedge clk);
    check("scan_last_index", 32'(out_index), 32'd3);
    check("scan_done_early", 32'(scan_done), 32'd0);
    @(negedge clk);
    check("scan_done_pulse", 32'(scan_done), 32'd1);
    check("scan_end_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("scan_done_clear", 32'(scan_done), 32'd0);
    out_ready = 1'b0;
    check_scan("scan");

    // Scan with backpressure and commands ignored while busy
    acc_bit.delete(); acc_idx.delete();
    scan_start = 1'b1; @(negedge clk);
    scan_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      out_ready = pat[k];
      load = (k < 5); din = 4'b1111;
      req = (k < 5); index = 2'd3;
      @(negedge clk);
    end
    load = 1'b0; req = 1'b0; out_ready = 1'b0;
    check("bp_done", 32'(scan_done), 32'd1);
    check("bp_word", 32'(word), 32'b0110);
    check_scan("bp");
    @(negedge clk);

    // load beats req; then abort a scan at bit 2 with reset
    load = 1'b1; din = 4'b0001; req = 1'b1; index = 2'd0; @(negedge clk);
    load = 1'b0; req = 1'b0;
    check("prio_word", 32'(word), 32'b0001);
    check("prio_valid", 32'(out_valid), 32'd0);
    scan_start = 1'b1; out_ready = 1'b1; @(negedge clk);
    scan_start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_index", 32'(out_index), 32'd2);
    #1 rst_n = 1'b0; #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_word", 32'(word), 32'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b0;

    // Back-to-back single reads with req held high
    load = 1'b1; din = 4'b1010; @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      req = 1'b1; index = IDXW'(k % 4); out_ready = 1'b1;
      @(negedge clk);
    end
    req = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

`ifdef BIT_GET_READER_POPCOUNT_EN
    load = 1'b1; din = 4'b1011; @(negedge clk);
    load = 1'b0;
    check("pop_three", 32'(ones_count), 32'd3);
    load = 1'b1; din = 4'b0000; @(negedge clk);
    load = 1'b0;
    check("pop_zero", 32'(ones_count), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
